// File: rtl/sw_pkg.sv
// Shared switch-input definitions: level polarity, channel count and
// the default debounce interval used by the input-conditioning stage.
package sw_pkg;

    // Switch pins and debounced levels are active-low.
    typedef enum logic {
        SW_PRESSED  = 1'b0,
        SW_RELEASED = 1'b1
    } sw_level_e;

    localparam int unsigned NUM_SW                  = 4;
    // 5 ms at 50 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/sw_debounce_4_if.sv
// Switch bundle between the raw pins, the debouncer and its consumers.
interface sw_debounce_4_if;
    import sw_pkg::*;

    logic              SW1_IN;
    logic              SW2_IN;
    logic              SW3_IN;
    logic              SW4_IN;
    logic              SW1;
    logic              SW2;
    logic              SW3;
    logic              SW4;
    logic [NUM_SW-1:0] PRESS;
    logic [NUM_SW-1:0] RELEASE;
    logic              CHG;

    // Pin side: drives the raw switches, observes the cleaned levels.
    modport master (
        output SW1_IN, SW2_IN, SW3_IN, SW4_IN,
        input  SW1, SW2, SW3, SW4, PRESS, RELEASE, CHG
    );

    // Debouncer side.
    modport slave (
        input  SW1_IN, SW2_IN, SW3_IN, SW4_IN,
        output SW1, SW2, SW3, SW4, PRESS, RELEASE, CHG
    );

endinterface

// File: rtl/debounce_ch.sv
// One switch channel: 2-FF synchroniser, stability counter, held level
// and registered one-cycle press/release strobes.
module debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic sw_raw_i,
    output logic sw_o,
    output logic press_o,
    output logic release_o,
    output logic qual_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             held_q;
    logic             held_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Bring the asynchronous pin into the clock domain; idle is released.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s1_q <= SW_RELEASED;
            s2_q <= SW_RELEASED;
        end else begin
            s1_q <= sw_raw_i;
            s2_q <= s1_q;
        end
    end

    // Count consecutive disagreement; adopt the new level at terminal count.
    always_comb begin
        cnt_d     = '0;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q != held_q) begin
            if (cnt_q == CNT_LAST) begin
                held_d    = s2_q;
                press_d   = (s2_q == SW_PRESSED);
                release_d = (s2_q == SW_RELEASED);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Held level, counter and strobes; reset discards any partial count.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            held_q    <= SW_RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            held_q    <= held_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign sw_o      = held_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    // Qualification this edge, so the top can register CHG alongside the strobes.
    assign qual_o    = press_d | release_d;

endmodule

// File: rtl/sw_debounce_4.sv
// Four-channel switch debouncer feeding the switch-weighting/LED logic.
module sw_debounce_4
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            CLK,
    input  logic            RSTN,
    sw_debounce_4_if.slave  bus
);

    logic [NUM_SW-1:0] raw;
    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] rel;
    logic [NUM_SW-1:0] qual;
    logic              chg_q;
    logic              chg_d;

    assign raw = {bus.SW4_IN, bus.SW3_IN, bus.SW2_IN, bus.SW1_IN};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i     (CLK),
            .rstn_i    (RSTN),
            .sw_raw_i  (raw[i]),
            .sw_o      (sw[i]),
            .press_o   (press[i]),
            .release_o (rel[i]),
            .qual_o    (qual[i])
        );
    end

    assign chg_d = |qual;

    // CHG is registered from the same-edge qualification so it lines up with the strobes.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign bus.SW1     = sw[0];
    assign bus.SW2     = sw[1];
    assign bus.SW3     = sw[2];
    assign bus.SW4     = sw[3];
    assign bus.PRESS   = press;
    assign bus.RELEASE = rel;
    assign bus.CHG     = chg_q;

endmodule
